// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   md_op_e    - command encodings driven on op (6 and 7 are no-ops)
//   md_state_e - sequencer FSM states
//   cnt_width  - iteration counter width for a given operand width
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  localparam int MD_WIDTH = 32;

  // Counter must be able to hold values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/md_seq_if.sv
// md_seq_if: command/result bundle between the main control FSM and md_seq.
//   start/op/a/b        - command strobe, opcode and rs/rt operands
//   busy/done/dz/hi/lo  - status and the HI/LO register pair
// master = control FSM side, slave = md_seq side.
interface md_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/md_step.sv
// md_step: one combinational iteration of the multiply/divide loop.
//   mode    - 0: shift-add multiply step, 1: restoring divide step
//   acc     - {upper, lower} working register
//             multiply: {partial product, remaining multiplier bits}
//             divide:   {partial remainder, remaining dividend / quotient bits}
//   opd     - multiplicand (multiply) or divisor (divide) magnitude
//   acc_nxt - working register after this iteration
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_ext_s;
  logic [WIDTH:0] diff_s;
  logic           ok_s;

  // Compute both candidate steps and select by mode.
  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB is set; the
    // carry lands in bit WIDTH and is shifted back down with the product.
    sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
    // Divide: remainder shifted left with the next dividend bit brought in.
    // Remainder < divisor, so a borrow in bit WIDTH means the trial failed.
    rem_ext_s = acc[2*WIDTH-1:WIDTH-1];
    diff_s    = rem_ext_s - {1'b0, opd};
    ok_s      = ~diff_s[WIDTH];
    if (mode) begin
      acc_nxt = {(ok_s ? diff_s[WIDTH-1:0] : rem_ext_s[WIDTH-1:0]),
                 acc[WIDTH-2:0], ok_s};
    end else begin
      acc_nxt = {sum_s, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_seq.sv
// md_seq: iterative multiply/divide sequencer owning the HI/LO pair.
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - md_seq_if slave: start/op/a/b in; busy/done/dz/hi/lo out
// MULT/MULTU/DIV/DIVU run on operand magnitudes for WIDTH iterations, then
// one FIX cycle applies signs and commits HI/LO. MTHI/MTLO and divide by
// zero complete on the accepting edge without raising busy.
module md_seq
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic    clk,
  input logic    rst,
  md_seq_if.slave bus
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e          state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0]   opd_r, opd_s;
  logic               neg_q_r, neg_q_s;
  logic               neg_r_r, neg_r_s;
  logic               is_div_r, is_div_s;
  logic [WIDTH-1:0]   hi_r, hi_s;
  logic [WIDTH-1:0]   lo_r, lo_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               dz_r, dz_s;

  logic               signed_op_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [2*WIDTH-1:0] step_acc_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Single iteration datapath, mode follows the active loop state.
  md_step #(.WIDTH(WIDTH)) u_step (
    .mode    (state_r == DIV),
    .acc     (acc_r),
    .opd     (opd_r),
    .acc_nxt (step_acc_s)
  );

  // Operand magnitudes at acceptance and signed results at commit time.
  always_comb begin
    signed_op_s = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    a_neg_s     = signed_op_s & bus.a[WIDTH-1];
    b_neg_s     = signed_op_s & bus.b[WIDTH-1];
    a_mag_s     = a_neg_s ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    b_mag_s     = b_neg_s ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    prod_s      = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
    quo_s       = neg_q_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s       = neg_r_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH])
                          : acc_r[2*WIDTH-1:WIDTH];
  end

  // FSM next-state and next register values.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    acc_s    = acc_r;
    opd_s    = opd_r;
    neg_q_s  = neg_q_r;
    neg_r_s  = neg_r_r;
    is_div_s = is_div_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    dz_s     = dz_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MD_MULT, MD_MULTU: begin
              state_s  = MUL;
              busy_s   = 1'b1;
              dz_s     = 1'b0;
              cnt_s    = {CNT_W{1'b0}};
              acc_s    = {{WIDTH{1'b0}}, b_mag_s};
              opd_s    = a_mag_s;
              neg_q_s  = a_neg_s ^ b_neg_s;
              neg_r_s  = 1'b0;
              is_div_s = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              if (bus.b == {WIDTH{1'b0}}) begin
                // No iteration; HI/LO untouched, flag and complete now.
                dz_s   = 1'b1;
                done_s = 1'b1;
              end else begin
                state_s  = DIV;
                busy_s   = 1'b1;
                dz_s     = 1'b0;
                cnt_s    = {CNT_W{1'b0}};
                acc_s    = {{WIDTH{1'b0}}, a_mag_s};
                opd_s    = b_mag_s;
                neg_q_s  = a_neg_s ^ b_neg_s;
                neg_r_s  = a_neg_s;
                is_div_s = 1'b1;
              end
            end
            MD_MTHI: begin
              hi_s   = bus.a;
              dz_s   = 1'b0;
              done_s = 1'b1;
            end
            MD_MTLO: begin
              lo_s   = bus.a;
              dz_s   = 1'b0;
              done_s = 1'b1;
            end
            default: begin
              // Opcodes 6 and 7 are ignored entirely.
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        acc_s = step_acc_s;
        cnt_s = cnt_r + 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = state_r;
        end
      end
      FIX: begin
        if (is_div_r) begin
          lo_s = quo_s;
          hi_s = rem_s;
        end else begin
          {hi_s, lo_s} = prod_s;
        end
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      opd_r    <= {WIDTH{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      is_div_r <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      acc_r    <= acc_s;
      opd_r    <= opd_s;
      neg_q_r  <= neg_q_s;
      neg_r_r  <= neg_r_s;
      is_div_r <= is_div_s;
      hi_r     <= hi_s;
      lo_r     <= lo_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      dz_r     <= dz_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dz   = dz_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: self-checking bench for md_seq. Directed vectors plus random
// commands, each compared against a reference model using 64-bit integer
// multiply, divide and modulo.
module tb_md_seq;
  import md_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] ref_hi, ref_lo;
  logic        ref_dz;

  md_seq_if #(.WIDTH(W)) bus ();

  md_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: kind 0 = ignored, 1 = immediate completion, 2 = iterative.
  task automatic model_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int kind);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    kind = 0;
    if (op <= 3'd5) ref_dz = 1'b0;
    case (op)
      3'd0: begin p = sa * sb; {ref_hi, ref_lo} = p; kind = 2; end
      3'd1: begin p = ua * ub; {ref_hi, ref_lo} = p; kind = 2; end
      3'd2: begin
        if (b == 32'h0) begin ref_dz = 1'b1; kind = 1; end
        else begin sq = sa / sb; sr = sa % sb; ref_lo = sq[31:0]; ref_hi = sr[31:0]; kind = 2; end
      end
      3'd3: begin
        if (b == 32'h0) begin ref_dz = 1'b1; kind = 1; end
        else begin p = ua / ub; ref_lo = p[31:0]; p = ua % ub; ref_hi = p[31:0]; kind = 2; end
      end
      3'd4: begin ref_hi = a; kind = 1; end
      3'd5: begin ref_lo = a; kind = 1; end
      default: kind = 0;
    endcase
  endtask

  // Issue one command, watch 40 cycles, check timing, HI/LO hold and result.
  // inject_at >= 0 pulses an MTHI while the command is (expected) busy.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at);
    int kind, busy_n, done_n, done_at;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = ref_hi;
    prev_lo = ref_lo;
    model_cmd(op, a, b, kind);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == inject_at) begin
        bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'hDEAD;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) begin
        busy_n++;
        chk("hold_hi", bus.hi, prev_hi);
        chk("hold_lo", bus.lo, prev_lo);
      end
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      @(negedge clk);
    end
    chk("busy_cycles", busy_n, (kind == 2) ? 33 : 0);
    chk("done_count", done_n, (kind == 0) ? 0 : 1);
    chk("done_at", done_at, (kind == 2) ? 33 : ((kind == 1) ? 0 : -1));
    chk("hi", bus.hi, ref_hi);
    chk("lo", bus.lo, ref_lo);
    chk("dz", bus.dz, ref_dz);
    chk("busy_idle", bus.busy, 0);
  endtask

  logic [2:0]  tp_op [5] = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd2};
  logic [31:0] tp_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9, 32'h80000000};
  logic [31:0] tp_b  [5] = '{32'hFFFFFFFF, 32'd5, 32'd7, 32'd2, 32'hFFFFFFFF};
  logic [31:0] tp_hi [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h0};
  logic [31:0] tp_lo [5] = '{32'h00000001, 32'hFFFFFFF1, 32'd14, 32'hFFFFFFFD, 32'h80000000};

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int sel;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'h0; bus.b = 32'h0;
    ref_hi = 32'h0; ref_lo = 32'h0; ref_dz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.dz, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    rst = 1'b1;

    // MTHI pulsed at edge 10 of a MULTU must be dropped.
    run_cmd(MD_MULTU, 32'd3, 32'd4, 9);
    chk("inject_hi", bus.hi, 32'h0);
    chk("inject_lo", bus.lo, 32'd12);

    for (int t = 0; t < 5; t++) begin
      run_cmd(tp_op[t], tp_a[t], tp_b[t], -1);
      chk("tp_hi", bus.hi, tp_hi[t]);
      chk("tp_lo", bus.lo, tp_lo[t]);
    end

    // Divide by zero leaves preloaded HI/LO alone; no-op keeps dz sticky.
    run_cmd(MD_MTHI, 32'h11, 32'h0, -1);
    run_cmd(MD_MTLO, 32'h22, 32'h0, -1);
    run_cmd(MD_DIVU, 32'd5, 32'h0, -1);
    chk("dz_hi", bus.hi, 32'h11);
    chk("dz_lo", bus.lo, 32'h22);
    chk("dz_flag", bus.dz, 1);
    run_cmd(3'd7, 32'h1234, 32'h5678, -1);
    chk("dz_sticky", bus.dz, 1);

    // Asynchronous reset in the middle of a MULTU.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_dz", bus.dz, 0);
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    ref_hi = 32'h0; ref_lo = 32'h0; ref_dz = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_cmd(MD_MULTU, 32'd2, 32'd3, -1);
    chk("post_rst_lo", bus.lo, 32'd6);

    // Random commands with biased corner operands.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 9));
      run_cmd(rop, ra, rb, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
